// File: rtl/sha256_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sha256_pkg
//  Purpose  : Shared SHA-256 digest geometry and collector state encoding.
//             The core controller and the digest collector both size their
//             64-beat output window from these constants.
//  Revision : 1.0 - initial release
// ============================================================================
package sha256_pkg;

  localparam int NIBBLE_W = 4;
  localparam int DIGEST_W = 256;
  localparam int BEATS    = DIGEST_W / NIBBLE_W;

  // HOLD presents a digest; DRAIN also presents it but skips the rest of a
  // window that began while the host was still stalled.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2,
    DRAIN   = 2'd3
  } collector_state_t;

endpackage : sha256_pkg
`default_nettype wire

// File: rtl/sha256_digest_collector_if.sv
`default_nettype none
// ============================================================================
//  Module   : sha256_digest_collector_if
//  Purpose  : Digest beat stream from the core plus the host valid/ready
//             result channel and the error pulses.
//  Revision : 1.0 - initial release
// ============================================================================
interface sha256_digest_collector_if #(
  parameter int NIBBLE_W = sha256_pkg::NIBBLE_W,
  parameter int DIGEST_W = sha256_pkg::DIGEST_W
) ();

  logic                output_enable;
  logic [NIBBLE_W-1:0] digest_nibble;
  logic                digest_ready;
  logic                digest_valid;
  logic [DIGEST_W-1:0] digest;
  logic                short_err;
  logic                overrun;

  // Core/host side: drives beats and the ready strobe.
  modport master (
    output output_enable,
    output digest_nibble,
    output digest_ready,
    input  digest_valid,
    input  digest,
    input  short_err,
    input  overrun
  );

  // Collector side.
  modport slave (
    input  output_enable,
    input  digest_nibble,
    input  digest_ready,
    output digest_valid,
    output digest,
    output short_err,
    output overrun
  );

endinterface : sha256_digest_collector_if
`default_nettype wire

// File: rtl/sha256_digest_collector_nibble_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module   : nibble_shift_reg
//  Purpose  : Shift-in register. clr_i empties it, shift_i appends din_i at
//             the LSB end; both together start a fresh value with din_i.
//  Revision : 1.0 - initial release
// ============================================================================
module nibble_shift_reg #(
  parameter int WIDTH = 256,
  parameter int STEP  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             shift_i,
  input  logic [STEP-1:0]  din_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] reg_q;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] reg_d;

  // Next value: optionally cleared, then optionally shifted by one beat.
  always_comb begin
    base  = clr_i ? '0 : reg_q;
    reg_d = shift_i ? {base[WIDTH-STEP-1:0], din_i} : base;
  end

  // Register only updates when asked, so it holds a finished digest.
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_q <= '0;
    end else if (clr_i || shift_i) begin
      reg_q <= reg_d;
    end
  end

  assign q_o = reg_q;

endmodule : nibble_shift_reg
`default_nettype wire

// File: rtl/sha256_digest_collector.sv
`default_nettype none
// ============================================================================
//  Module   : sha256_digest_collector
//  Purpose  : Assembles the core's 64 x 4-bit digest beats into a 256-bit
//             word, holds it behind valid/ready, and flags truncated windows
//             and windows lost while the host stalled.
//  Revision : 1.0 - initial release
// ============================================================================
module sha256_digest_collector #(
  parameter int NIBBLE_W = sha256_pkg::NIBBLE_W,
  parameter int DIGEST_W = sha256_pkg::DIGEST_W,
  parameter int BEATS    = sha256_pkg::BEATS
) (
  input  logic clk,
  input  logic reset,
  sha256_digest_collector_if.slave bus
);

  localparam int               CNT_W     = $clog2(BEATS + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0] ONE_BEAT  = CNT_W'(1);

  sha256_pkg::collector_state_t state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                oe_d_q;
  logic                short_err_q, short_err_d;
  logic                overrun_q, overrun_d;
  logic                acc_clr, acc_shift;
  logic [DIGEST_W-1:0] acc_q;
  logic                win_start;
  logic                handshake;
  logic                valid;

  // The accumulator doubles as the presented digest: it stops shifting in
  // HOLD/DRAIN, so it stays stable until the host takes it.
  nibble_shift_reg #(
    .WIDTH (DIGEST_W),
    .STEP  (NIBBLE_W)
  ) u_acc (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (acc_clr),
    .shift_i (acc_shift),
    .din_i   (bus.digest_nibble),
    .q_o     (acc_q)
  );

  // oe_d_q resets high so a window already in flight at reset is skipped.
  assign win_start = bus.output_enable && !oe_d_q;
  assign valid     = (state_q == sha256_pkg::HOLD) || (state_q == sha256_pkg::DRAIN);
  assign handshake = valid && bus.digest_ready;

  // State, beat counter, edge-detect history and the one-cycle error pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= sha256_pkg::IDLE;
      cnt_q       <= '0;
      oe_d_q      <= 1'b1;
      short_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      oe_d_q      <= bus.output_enable;
      short_err_q <= short_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // Next-state logic and accumulator controls.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_clr     = 1'b0;
    acc_shift   = 1'b0;
    short_err_d = 1'b0;
    overrun_d   = 1'b0;

    case (state_q)
      sha256_pkg::IDLE: begin
        // Only a fresh window is accepted; tails of long windows are ignored.
        if (win_start) begin
          acc_clr   = 1'b1;
          acc_shift = 1'b1;
          cnt_d     = ONE_BEAT;
          state_d   = sha256_pkg::COLLECT;
        end
      end

      sha256_pkg::COLLECT: begin
        if (bus.output_enable) begin
          acc_shift = 1'b1;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) begin
            state_d = sha256_pkg::HOLD;
          end
        end else begin
          short_err_d = 1'b1;
          acc_clr     = 1'b1;
          cnt_d       = '0;
          state_d     = sha256_pkg::IDLE;
        end
      end

      sha256_pkg::HOLD: begin
        if (handshake) begin
          if (win_start) begin
            // Host freed the slot in time: this beat is beat 0 of the next digest.
            acc_clr   = 1'b1;
            acc_shift = 1'b1;
            cnt_d     = ONE_BEAT;
            state_d   = sha256_pkg::COLLECT;
          end else begin
            state_d = sha256_pkg::IDLE;
          end
        end else if (win_start) begin
          overrun_d = 1'b1;
          state_d   = sha256_pkg::DRAIN;
        end
      end

      sha256_pkg::DRAIN: begin
        // The lost window has no usable start once accepted, so IDLE waits
        // for its end before collecting again.
        if (handshake) begin
          state_d = sha256_pkg::IDLE;
        end else if (!bus.output_enable) begin
          state_d = sha256_pkg::HOLD;
        end
      end

      default: begin
        state_d = sha256_pkg::IDLE;
      end
    endcase
  end

  assign bus.digest_valid = valid;
  assign bus.digest       = acc_q;
  assign bus.short_err    = short_err_q;
  assign bus.overrun      = overrun_q;

endmodule : sha256_digest_collector
`default_nettype wire

// File: tb/tb_sha256_digest_collector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sha256_digest_collector
//  Purpose  : Scoreboard bench for the digest collector. Stimulus pushes the
//             expected digests and flag pulses; a negedge monitor compares.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sha256_digest_collector;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [255:0] exp_digests[$];
  string        exp_flags[$];

  localparam logic [255:0] T1_DIGEST =
    256'h0123456789ABCDEF0123456789ABCDEF0123456789ABCDEF0123456789ABCDEF;

  always #5 clk = ~clk;

  sha256_digest_collector_if bus ();

  sha256_digest_collector dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got an event, expected none", name);
  endtask

  task automatic flag_event(input string name);
    if (exp_flags.size() == 0) begin
      note_fail({"unexpected_", name});
    end else begin
      checks++;
      if (exp_flags[0] != name) begin
        errors++;
        $display("FAIL flag_order: got %s expected %s", name, exp_flags[0]);
      end
      void'(exp_flags.pop_front());
    end
  endtask

  function automatic logic [255:0] exp_digest(input int k, input int s);
    logic [255:0] d;
    d = '0;
    for (int i = 0; i < 64; i++) begin
      d[255-4*i -: 4] = 4'((i * k + s) & 15);
    end
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int i, input int k, input int s);
    bus.output_enable = 1'b1;
    bus.digest_nibble = 4'((i * k + s) & 15);
    tick();
  endtask

  task automatic window(input int n, input int k, input int s);
    for (int i = 0; i < n; i++) begin
      beat(i, k, s);
    end
    bus.output_enable = 1'b0;
    tick();
  endtask

  // Monitor: every presented digest must equal the oldest expected one,
  // and is retired when the host accepts it.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.digest_valid) begin
        if (exp_digests.size() == 0) begin
          note_fail("unexpected_valid");
        end else begin
          chk("digest", bus.digest, exp_digests[0]);
          if (bus.digest_ready) void'(exp_digests.pop_front());
        end
      end
      if (bus.short_err) flag_event("short_err");
      if (bus.overrun)   flag_event("overrun");
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.output_enable = 1'b0;
    bus.digest_nibble = '0;
    bus.digest_ready  = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    chk("reset_valid",   bus.digest_valid, 0);
    chk("reset_short",   bus.short_err, 0);
    chk("reset_overrun", bus.overrun, 0);
    chk("reset_digest",  bus.digest, 0);
    reset = 1'b0;
    tick();

    // Single digest, host always ready.
    bus.digest_ready = 1'b1;
    exp_digests.push_back(T1_DIGEST);
    for (int i = 0; i < 64; i++) beat(i, 1, 0);
    chk("latency_valid", bus.digest_valid, 1);
    bus.output_enable = 1'b0;
    tick();
    chk("valid_one_cycle", bus.digest_valid, 0);

    // Host stall for ~100 cycles.
    bus.digest_ready = 1'b0;
    exp_digests.push_back(exp_digest(3, 5));
    window(64, 3, 5);
    repeat (99) tick();
    chk("stall_valid", bus.digest_valid, 1);
    bus.digest_ready = 1'b1;
    tick();
    chk("post_transfer_valid", bus.digest_valid, 0);

    // Truncated window, then a clean one.
    exp_flags.push_back("short_err");
    for (int i = 0; i < 40; i++) beat(i, 5, 1);
    bus.output_enable = 1'b0;
    tick();
    chk("short_err_pulse", bus.short_err, 1);
    tick();
    chk("short_err_clear", bus.short_err, 0);
    chk("short_no_valid", bus.digest_valid, 0);
    exp_digests.push_back(exp_digest(7, 2));
    window(64, 7, 2);

    // Overrun: second window arrives while the first is unaccepted.
    bus.digest_ready = 1'b0;
    exp_digests.push_back(exp_digest(2, 9));
    window(64, 2, 9);
    exp_flags.push_back("overrun");
    window(64, 11, 4);
    chk("held_after_overrun", bus.digest_valid, 1);
    bus.digest_ready = 1'b1;
    tick();
    chk("overrun_transfer_valid", bus.digest_valid, 0);

    // Long window: beats 64..69 ignored.
    exp_digests.push_back(exp_digest(5, 3));
    window(70, 5, 3);
    chk("long_no_extra_valid", bus.digest_valid, 0);

    // Reset at beat 30 of a window; the remaining beats are ignored.
    for (int i = 0; i < 30; i++) beat(i, 9, 8);
    bus.output_enable = 1'b1;
    bus.digest_nibble = 4'((30 * 9 + 8) & 15);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midreset_valid",   bus.digest_valid, 0);
    chk("midreset_short",   bus.short_err, 0);
    chk("midreset_overrun", bus.overrun, 0);
    chk("midreset_digest",  bus.digest, 0);
    for (int i = 31; i < 40; i++) beat(i, 9, 8);
    bus.output_enable = 1'b0;
    tick();
    chk("midreset_no_short", bus.short_err, 0);
    exp_digests.push_back(exp_digest(13, 6));
    window(64, 13, 6);

    repeat (3) tick();
    chk("digests_left", 256'(exp_digests.size()), 0);
    chk("flags_left",   256'(exp_flags.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_sha256_digest_collector
`default_nettype wire
